// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
// The midpoint helper is sized for the default operand width.
package sar_pkg;

   localparam int SAR_WIDTH = 8;
   localparam int CNT_W     = $clog2(SAR_WIDTH + 2);

   typedef enum logic {
      IDLE   = 1'b0,
      SETTLE = 1'b1
   } sar_state_e;

   // One extra bit keeps hi-lo and the sum from wrapping at the top of the range.
   function automatic logic [SAR_WIDTH-1:0] mid_point(input logic [SAR_WIDTH-1:0] lo,
                                                      input logic [SAR_WIDTH-1:0] hi);
      logic [SAR_WIDTH:0] sum;
      sum = {1'b0, lo} + (({1'b0, hi} - {1'b0, lo}) >> 1);
      return sum[SAR_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/sar_search_ctrl.sv
// Binary-search initiator: drives probe values into a magnitude comparator and
// narrows [lo, hi] from its one-hot LT/EQ/GT answer until the operand is found.
module sar_search_ctrl
   import sar_pkg::*;
#(
   parameter int WIDTH       = SAR_WIDTH,
   parameter int CMP_LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             cmp_lt,
   input  logic             cmp_eq,
   input  logic             cmp_gt,
   output logic [WIDTH-1:0] probe,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic             err,
   output logic [WIDTH-1:0] result,
   output logic [CNT_W-1:0] probe_count
);

   localparam int WC_W = (CMP_LATENCY > 1) ? $clog2(CMP_LATENCY) : 1;
   localparam logic [WC_W-1:0] WAIT_RELOAD = WC_W'(CMP_LATENCY - 1);

   sar_state_e       state_q;
   logic [WIDTH-1:0] lo_q, hi_q, probe_q, result_q;
   logic [WC_W-1:0]  wait_q;
   logic [CNT_W-1:0] count_q;
   logic             busy_q, done_q, found_q, err_q;

   // Neighbours of the probe; only consumed on the side where they cannot wrap.
   logic [WIDTH-1:0] probe_dec_d, probe_inc_d;
   logic             onehot_d;

   assign probe_dec_d = probe_q - 1'b1;
   assign probe_inc_d = probe_q + 1'b1;
   assign onehot_d    = $onehot({cmp_lt, cmp_eq, cmp_gt});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         lo_q     <= '0;
         hi_q     <= '0;
         probe_q  <= '0;
         result_q <= '0;
         wait_q   <= '0;
         count_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         found_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  lo_q    <= '0;
                  hi_q    <= '1;
                  probe_q <= mid_point('0, '1);
                  count_q <= CNT_W'(1);
                  wait_q  <= WAIT_RELOAD;
                  busy_q  <= 1'b1;
                  found_q <= 1'b0;
                  err_q   <= 1'b0;
                  state_q <= SETTLE;
               end
            end
            SETTLE: begin
               if (abort) begin
                  busy_q  <= 1'b0;
                  found_q <= 1'b0;
                  err_q   <= 1'b0;
                  state_q <= IDLE;
               end else if (wait_q != '0) begin
                  wait_q <= wait_q - 1'b1;
               end else if (!onehot_d) begin
                  err_q   <= 1'b1;
                  found_q <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end else if (cmp_eq) begin
                  found_q  <= 1'b1;
                  result_q <= probe_q;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= IDLE;
               end else if (cmp_lt) begin
                  if (probe_q == lo_q) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     hi_q    <= probe_dec_d;
                     probe_q <= mid_point(lo_q, probe_dec_d);
                     count_q <= count_q + 1'b1;
                     wait_q  <= WAIT_RELOAD;
                  end
               end else begin
                  if (probe_q == hi_q) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end else begin
                     lo_q    <= probe_inc_d;
                     probe_q <= mid_point(probe_inc_d, hi_q);
                     count_q <= count_q + 1'b1;
                     wait_q  <= WAIT_RELOAD;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign probe       = probe_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign found       = found_q;
   assign err         = err_q;
   assign result      = result_q;
   assign probe_count = count_q;

endmodule
